imem_loader: RTL

Boot-time programmer for the single-cycle core's instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and drives a one-word-per-cycle write port into instruction memory, starting at byte address 0. While loading, it holds the core in reset through `cpu_hold`; when loading finishes, it releases the core to fetch from the freshly written image.

---
 rtl/imem_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> one-word-per-cycle IMEM writes.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] wa,
  output logic [31:0] wd,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    CHK,
    FINISH
  } state_t;

  localparam logic [16:0] MAX_LEN = 17'(DEPTH_WORDS);

  state_t      state_reg;
  logic [15:0] len_reg;
  logic [15:0] idx_reg;
  logic [1:0]  byte_cnt_reg;
  logic [31:0] word_reg;
  logic [31:0] word_next;
  logic [15:0] len_next;
  logic        take;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_reg;
`endif

  assign take     = byte_valid && byte_ready;
  assign len_next = {byte_data, len_reg[7:0]};
  assign cpu_hold = busy;

  // Incoming byte lands in the lane selected by its position within the word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_next[8*gi +: 8] = (byte_cnt_reg == 2'(gi)) ? byte_data : word_reg[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      idx_reg      <= '0;
      byte_cnt_reg <= '0;
      word_reg     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg     <= '0;
`endif
      byte_ready   <= 1'b0;
      we           <= 1'b0;
      wa           <= '0;
      wd           <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            err          <= 1'b0;
            idx_reg      <= '0;
            byte_cnt_reg <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
            busy         <= 1'b1;
            byte_ready   <= 1'b1;
            state_reg    <= LEN0;
          end
        end
        LEN0: begin
          if (take) begin
            len_reg[7:0] <= byte_data;
            state_reg    <= LEN1;
          end
        end
        LEN1: begin
          if (take) begin
            len_reg[15:8] <= byte_data;
            if (len_next == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_reg  <= CHK;
`else
              byte_ready <= 1'b0;
              done       <= 1'b1;
              state_reg  <= FINISH;
`endif
            end else if ({1'b0, len_next} > MAX_LEN) begin
              // Oversized image: refuse before touching memory.
              err        <= 1'b1;
              busy       <= 1'b0;
              byte_ready <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              state_reg  <= DATA;
            end
          end
        end
        DATA: begin
          if (take) begin
            word_reg     <= word_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg     <= csum_reg ^ byte_data;
`endif
            if (byte_cnt_reg == 2'd3) begin
              // Write port is loaded here so wa/wd stay stable outside we pulses.
              wa         <= {14'd0, idx_reg, 2'b00};
              wd         <= word_next;
              we         <= 1'b1;
              byte_ready <= 1'b0;
              state_reg  <= WRITE;
            end
          end
        end
        WRITE: begin
          idx_reg <= idx_reg + 16'd1;
          if (idx_reg + 16'd1 == len_reg) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            byte_ready <= 1'b1;
            state_reg  <= CHK;
`else
            done       <= 1'b1;
            state_reg  <= FINISH;
`endif
          end else begin
            byte_ready <= 1'b1;
            state_reg  <= DATA;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (take) begin
            byte_ready <= 1'b0;
            if (byte_data == csum_reg) begin
              done      <= 1'b1;
              state_reg <= FINISH;
            end else begin
              err       <= 1'b1;
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
`endif
        FINISH: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

endmodule
